// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared types and widths for the request/grant/commit/valid memory responder
package mem_if_pkg;
  localparam int DATA_W = 16;
  localparam int REQ_ADDR_W = 32;
  localparam int LAT_W = 4;
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE} state_t;
  function automatic logic [LAT_W-1:0] lat_load(input int lat);
    return LAT_W'(lat - 1);
  endfunction
endpackage

// File: rtl/mem_resp_array.sv
// mem_resp_array: single-port synchronous word RAM, registered read, write-enable
module mem_resp_array
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              memclk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge memclk)
    if (we) mem[addr] <= wdata;
  // only the read register is reset; array contents survive reset
  always_ff @(posedge memclk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-client responder with fixed read/write latency and round-robin arbitration
// MEM_RESPONDER_STATS_EN enables the rd_count/wr_count completion counters
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int READ_LAT  = 3,
  parameter int WRITE_LAT = 2
) (
  input  logic                  memclk,
  input  logic                  rst_n,
  input  logic                  readRequest,
  input  logic [REQ_ADDR_W-1:0] readAddress,
  output logic                  readRequestGrant,
  output logic                  readValid,
  output logic [DATA_W-1:0]     readData,
  input  logic                  writeRequest,
  input  logic [REQ_ADDR_W-1:0] writeAddress,
  input  logic [DATA_W-1:0]     writeData,
  output logic                  writeRequestGrant,
  output logic                  writeCommit,
  output logic                  busy,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
);
  state_t            st, st_n;
  logic [LAT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [DATA_W-1:0] wd, wd_n;
  logic              rr_wr, rr_wr_n;
  logic              rg_n, wg_n, rv_n, wc_n, we, re, pick_wr;
  logic              unused;
  assign unused  = ^{readAddress[REQ_ADDR_W-1:ADDR_W], writeAddress[REQ_ADDR_W-1:ADDR_W]};
  assign pick_wr = writeRequest && (!readRequest || rr_wr);
  assign busy    = st != IDLE;
  always_comb begin
    st_n    = st;
    cnt_n   = cnt;
    addr_n  = addr;
    wd_n    = wd;
    rr_wr_n = rr_wr;
    rg_n    = 1'b0;
    wg_n    = 1'b0;
    rv_n    = 1'b0;
    wc_n    = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    case (st)
      IDLE: if (readRequest || writeRequest) begin
        st_n    = pick_wr ? WR_WAIT : RD_WAIT;
        cnt_n   = pick_wr ? lat_load(WRITE_LAT) : lat_load(READ_LAT);
        addr_n  = pick_wr ? writeAddress[ADDR_W-1:0] : readAddress[ADDR_W-1:0];
        wd_n    = pick_wr ? writeData : wd;
        wg_n    = pick_wr;
        rg_n    = !pick_wr;
        // priority only moves when both types contend
        rr_wr_n = (readRequest && writeRequest) ? !pick_wr : rr_wr;
      end
      RD_WAIT: begin
        re    = cnt == '0;
        rv_n  = re;
        st_n  = re ? RD_DONE : RD_WAIT;
        cnt_n = re ? cnt : cnt - LAT_W'(1);
      end
      WR_WAIT: begin
        we    = cnt == '0;
        wc_n  = we;
        st_n  = we ? WR_DONE : WR_WAIT;
        cnt_n = we ? cnt : cnt - LAT_W'(1);
      end
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge memclk or negedge rst_n)
    if (!rst_n) begin
      st                <= IDLE;
      cnt               <= '0;
      addr              <= '0;
      wd                <= '0;
      rr_wr             <= 1'b1;
      readRequestGrant  <= 1'b0;
      writeRequestGrant <= 1'b0;
      readValid         <= 1'b0;
      writeCommit       <= 1'b0;
    end else begin
      st                <= st_n;
      cnt               <= cnt_n;
      addr              <= addr_n;
      wd                <= wd_n;
      rr_wr             <= rr_wr_n;
      readRequestGrant  <= rg_n;
      writeRequestGrant <= wg_n;
      readValid         <= rv_n;
      writeCommit       <= wc_n;
    end
  mem_resp_array #(.ADDR_W(ADDR_W)) u_array (
    .memclk(memclk),
    .rst_n (rst_n),
    .we    (we),
    .re    (re),
    .addr  (addr),
    .wdata (wd),
    .rdata (readData)
  );
`ifdef MEM_RESPONDER_STATS_EN
  always_ff @(posedge memclk or negedge rst_n)
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      rd_count <= rd_count + 32'(rv_n);
      wr_count <= wr_count + 32'(wc_n);
    end
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for mem_responder
module tb_mem_responder;
  import mem_if_pkg::*;
  localparam int READ_LAT = 3;
  localparam int WRITE_LAT = 2;
  logic        memclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        readRequest = 1'b0, writeRequest = 1'b0;
  logic [31:0] readAddress = '0, writeAddress = '0;
  logic [15:0] writeData = '0;
  logic        readRequestGrant, readValid, writeRequestGrant, writeCommit, busy;
  logic [15:0] readData;
  logic [31:0] rd_count, wr_count;
  always #5 memclk = ~memclk;
  mem_responder #(.ADDR_W(10), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)) dut (
    .memclk(memclk), .rst_n(rst_n),
    .readRequest(readRequest), .readAddress(readAddress), .readRequestGrant(readRequestGrant),
    .readValid(readValid), .readData(readData),
    .writeRequest(writeRequest), .writeAddress(writeAddress), .writeData(writeData),
    .writeRequestGrant(writeRequestGrant), .writeCommit(writeCommit),
    .busy(busy), .rd_count(rd_count), .wr_count(wr_count)
  );
  int checks = 0, passed = 0;
  int n_grant = 0, n_rv = 0, n_wc = 0;
  int exp_grant = 0, exp_rv = 0, exp_wc = 0;
  int n_rd = 0, n_wr = 0;
  int n, snap;
  logic [15:0] sb[$];
  logic [15:0] model[1024];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  function automatic int expc(input int v);
`ifdef MEM_RESPONDER_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction
  always @(negedge memclk) begin
    n_grant += int'(readRequestGrant) + int'(writeRequestGrant);
    n_wc += int'(writeCommit);
    if (readRequestGrant | writeRequestGrant | readValid | writeCommit)
      chk("pulse_exclusive", $countones({readRequestGrant, writeRequestGrant, readValid, writeCommit}), 1);
    if (readValid) begin
      n_rv++;
      if (sb.size() == 0) begin
        checks++;
        $error("FAIL sb_underflow observed=readValid expected=no_valid");
      end else chk("readData", readData, sb.pop_front());
    end
  end
  task automatic wr(input logic [31:0] a, input logic [15:0] d, input int hold);
    int k = 0;
    writeRequest = 1'b1; writeAddress = a; writeData = d; model[a[9:0]] = d;
    do begin @(negedge memclk); k++; end while (!writeRequestGrant && k < 20);
    chk("wr_grant_lat", k, 1);
    exp_grant++;
    repeat (hold) @(negedge memclk);
    writeRequest = 1'b0;
    k = hold;
    while (!writeCommit && k < 20) begin @(negedge memclk); k++; end
    chk("wr_commit_lat", k, WRITE_LAT);
    n_wr++; exp_wc++;
    @(negedge memclk);
    chk("wr_idle", busy, 0);
  endtask
  task automatic rd(input logic [31:0] a, input int hold);
    int k = 0;
    readRequest = 1'b1; readAddress = a; sb.push_back(model[a[9:0]]);
    do begin @(negedge memclk); k++; end while (!readRequestGrant && k < 20);
    chk("rd_grant_lat", k, 1);
    exp_grant++;
    repeat (hold) @(negedge memclk);
    readRequest = 1'b0;
    k = hold;
    while (!readValid && k < 20) begin @(negedge memclk); k++; end
    chk("rd_valid_lat", k, READ_LAT);
    n_rd++; exp_rv++;
    @(negedge memclk);
    chk("rd_idle", busy, 0);
  endtask
  task automatic contest(input logic wr_first);
    int k = 0;
    readRequest = 1'b1; readAddress = 32'd5;
    writeRequest = 1'b1; writeAddress = 32'd6; writeData = 16'h1234;
    model[6] = 16'h1234; sb.push_back(model[5]);
    @(negedge memclk);
    chk("contest_wgrant", writeRequestGrant, wr_first);
    chk("contest_rgrant", readRequestGrant, !wr_first);
    exp_grant += 2; exp_rv++; exp_wc++; n_rd++; n_wr++;
    if (wr_first) writeRequest = 1'b0; else readRequest = 1'b0;
    do begin @(negedge memclk); k++; end
    while (!(wr_first ? readRequestGrant : writeRequestGrant) && k < 20);
    chk("contest_gap", k, wr_first ? WRITE_LAT + 2 : READ_LAT + 2);
    readRequest = 1'b0; writeRequest = 1'b0;
    repeat (8) @(negedge memclk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0; readRequest = 1'b0; writeRequest = 1'b0;
    sb.delete(); n_rd = 0; n_wr = 0;
    repeat (2) @(negedge memclk);
    rst_n = 1'b1;
    @(negedge memclk);
  endtask
  initial begin
    repeat (2) @(negedge memclk);
    chk("rst_busy", busy, 0);
    chk("rst_grants", {readRequestGrant, writeRequestGrant}, 0);
    chk("rst_pulses", {readValid, writeCommit}, 0);
    chk("rst_rdata", readData, 0);
    chk("rst_counts", rd_count | wr_count, 0);
    rst_n = 1'b1;
    @(negedge memclk);
    wr(32'd5, 16'hABCD, 0);
    rd(32'd5, 0);
    repeat (3) @(negedge memclk);
    chk("rd_hold", readData, 16'hABCD);
    do_reset();
    contest(1'b1);
    contest(1'b0);
    chk("rd_count_mid", rd_count, expc(n_rd));
    chk("wr_count_mid", wr_count, expc(n_wr));
    wr(32'h0000_0407, 16'h5555, 1);
    rd(32'd7, 1);
    readRequest = 1'b1; readAddress = 32'd5; n = 0;
    do begin @(negedge memclk); n++; end while (!readRequestGrant && n < 20);
    chk("rst_mid_grant", n, 1);
    exp_grant++;
    #1 rst_n = 1'b0; readRequest = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_outs", {readRequestGrant, writeRequestGrant, readValid, writeCommit}, 0);
    chk("rst_mid_rdata", readData, 0);
    chk("rst_mid_counts", rd_count | wr_count, 0);
    sb.delete(); n_rd = 0; n_wr = 0; snap = n_rv;
    repeat (READ_LAT + 2) @(negedge memclk);
    chk("rst_mid_no_valid", n_rv, snap);
    rst_n = 1'b1;
    @(negedge memclk);
    rd(32'd5, 0);
    do_reset();
    for (int i = 0; i < 1024; i++) wr(i, 16'(65535 - i), 0);
    for (int i = 0; i < 1024; i++) rd(i, 0);
    #1;
    chk("rd_count_final", rd_count, expc(1024));
    chk("wr_count_final", wr_count, expc(1024));
    chk("total_grants", n_grant, exp_grant);
    chk("total_valids", n_rv, exp_rv);
    chk("total_commits", n_wc, exp_wc);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning array depth is 2**ADDR_W 16-bit words.
REQ-002 SHALL have parameter READ_LAT, default 3, meaning grant-to-readValid cycles (legal 2..15).
REQ-003 SHALL have parameter WRITE_LAT, default 2, meaning grant-to-writeCommit cycles (legal 1..15).
REQ-004 SHALL use one clock and one reset: the clock is memclk; the reset is rst_n, asynchronous and active-low.
REQ-005 memclk  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 readRequest  in  1; readAddress  in  32; readRequestGrant  out  1; readValid  out  1; readData  out  16.
REQ-008 writeRequest  in  1; writeAddress  in  32; writeData  in  16; writeRequestGrant  out  1; writeCommit  out  1.
REQ-009 busy  out  1  high whenever state is not IDLE.
REQ-010 rd_count  out  32 and wr_count  out  32  completed-transaction counters (see Configuration).

Function
REQ-011 SHALL be the responder side of the request/grant/commit/valid memory-client protocol, serving requests from an internal word array.
REQ-012 SHALL implement states IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE.
REQ-013 IDLE: a sampled request makes the FSM assert the matching grant for exactly one cycle in the next cycle and latch address (and writeData) at that edge.
REQ-014 Simultaneous readRequest and writeRequest in IDLE SHALL be granted round-robin: the type not served last wins; after reset, write wins first.
REQ-015 Requests SHALL be ignored outside IDLE; the initiator holds a request until it sees the grant, then drops it.
REQ-016 Address SHALL use bits [ADDR_W-1:0] only; upper bits ignored (wrap-around alias, no error).
REQ-017 Read: readValid SHALL pulse exactly READ_LAT cycles after the grant cycle, with readData equal to the array word at the latched address.
REQ-018 readData SHALL hold its value until the next readValid.
REQ-019 Write: the array word SHALL be written and writeCommit SHALL pulse exactly WRITE_LAT cycles after the grant cycle.
REQ-020 RD_DONE/WR_DONE SHALL last one cycle (the pulse cycle) and return to IDLE; a new grant is possible at the earliest one cycle later.
REQ-021 Latency counter SHALL be 4 bits, loaded at grant, decremented per cycle, no wrap.
REQ-022 Grant, readValid and writeCommit SHALL never be high in the same cycle.
REQ-023 A read of an address committed earlier SHALL return the committed data (no stale read).

Reset
REQ-024 rst_n low SHALL force IDLE, all outputs 0, counters 0, round-robin to write-first, at any time, including mid-transaction.
REQ-025 A transaction in flight at reset SHALL be dropped without commit/valid; array contents SHALL NOT be cleared.

Configuration
REQ-026 Macro MEM_RESPONDER_STATS_EN defined: rd_count increments on each readValid and wr_count on each writeCommit, wrapping at 2**32.
REQ-027 Without MEM_RESPONDER_STATS_EN: rd_count and wr_count SHALL be tied to 0 and no counter logic compiled.

Structure
REQ-028 Package mem_if_pkg SHALL hold the state enum, DATA_W=16, REQ_ADDR_W=32 and the latency-counter width.
REQ-029 Sub-module mem_resp_array SHALL be a single-port synchronous RAM (registered read, write-enable) of 2**ADDR_W x 16.

Verification
REQ-030 Write 0xABCD to address 5 -> grant 1 cycle after request, writeCommit 2 cycles after grant; read address 5 -> readValid 3 cycles after grant, readData=0xABCD.
REQ-031 Same-cycle read (addr 5) and write (addr 6, 0x1234) after reset -> write granted first, read granted after WR_DONE+1; repeat -> read first.
REQ-032 Write 0x5555 to address 0x00000407 -> read address 7 returns 0x5555 (alias at ADDR_W=10).
REQ-033 rst_n low during RD_WAIT -> no readValid, busy=0, outputs 0; then read of previously written address 5 still returns 0xABCD.
REQ-034 1024 sequential writes of 65535-addr then reads -> every readData matches; with MEM_RESPONDER_STATS_EN rd_count=wr_count=1024, without both 0.
REQ-035 Request held high through grant cycle -> exactly one grant and one completion per transaction.
